// File: rtl/iir_coeff_loader.sv
// Streams Q4.11 coefficient words into the IIR coefficient bank using the a0/a1/b1 address layout.
// Optional bank readback verification is enabled by defining IIR_COEFF_READBACK_EN.
`timescale 1ns/1ps
module iir_coeff_loader #(
    parameter int ORDER  = 3,
    parameter int Y_BASE = 15,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int NWORDS = 3 * ORDER;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        VERIFY = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t     state_r;
    logic [2:0] k_r;
    logic [1:0] j_r;
    logic       last_word_s;

    // Bank layout: a0 at 2k, a1 at 2k+1, b1 at Y_BASE+k.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [2:0] k, input logic [1:0] j);
        logic [ADDR_W-1:0] kk;
        kk = ADDR_W'(k);
        case (j)
            2'd0:    slot_addr = {kk[ADDR_W-2:0], 1'b0};
            2'd1:    slot_addr = {kk[ADDR_W-2:0], 1'b1};
            2'd2:    slot_addr = ADDR_W'(Y_BASE) + kk;
            default: slot_addr = {ADDR_W{1'b0}};
        endcase
    endfunction

    assign last_word_s = (j_r == 2'd2) && (k_r == 3'(ORDER - 1));

`ifdef IIR_COEFF_READBACK_EN
    localparam int IDX_W = $clog2(NWORDS + 1);

    logic [15:0]      shadow_r [NWORDS];
    logic [IDX_W-1:0] widx_r;
    logic [IDX_W-1:0] vidx_r;
    logic [2:0]       rk_r;
    logic [1:0]       rj_r;
    logic             err_r;
    logic             mismatch_s;

    assign error = err_r;
    // Read data in verify cycle v answers the read issued in cycle v-1.
    assign mismatch_s = (vidx_r != {IDX_W{1'b0}}) &&
                        (rd_data != shadow_r[vidx_r - IDX_W'(1'b1)]);
`else
    logic unused_rd_data_s;

    assign unused_rd_data_s = ^rd_data;
    assign rd_en            = 1'b0;
    assign rd_addr          = {ADDR_W{1'b0}};
    assign error            = 1'b0;
`endif

    // Sequencer: handshake, section/slot counters, bank strobes and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            k_r      <= 3'd0;
            j_r      <= 2'd0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= {ADDR_W{1'b0}};
            wr_data  <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef IIR_COEFF_READBACK_EN
            rd_en    <= 1'b0;
            rd_addr  <= {ADDR_W{1'b0}};
            widx_r   <= {IDX_W{1'b0}};
            vidx_r   <= {IDX_W{1'b0}};
            rk_r     <= 3'd0;
            rj_r     <= 2'd0;
            err_r    <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_r[i] <= 16'h0000;
            end
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= LOAD;
                        k_r      <= 3'd0;
                        j_r      <= 2'd0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
`ifdef IIR_COEFF_READBACK_EN
                        widx_r   <= {IDX_W{1'b0}};
                        err_r    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= slot_addr(k_r, j_r);
                        wr_data <= in_data;
`ifdef IIR_COEFF_READBACK_EN
                        shadow_r[widx_r] <= in_data;
                        widx_r           <= widx_r + IDX_W'(1'b1);
`endif
                        if (last_word_s) begin
                            in_ready <= 1'b0;
                            state_r  <= DRAIN;
                            k_r      <= 3'd0;
                            j_r      <= 2'd0;
                        end else if (j_r == 2'd2) begin
                            j_r <= 2'd0;
                            k_r <= k_r + 3'd1;
                        end else begin
                            j_r <= j_r + 2'd1;
                        end
                    end
                end
                DRAIN: begin
`ifdef IIR_COEFF_READBACK_EN
                    state_r <= VERIFY;
                    rd_en   <= 1'b1;
                    rd_addr <= slot_addr(3'd0, 2'd0);
                    rk_r    <= 3'd0;
                    rj_r    <= 2'd1;
                    vidx_r  <= {IDX_W{1'b0}};
`else
                    state_r <= FINISH;
                    busy    <= 1'b0;
`endif
                end
`ifdef IIR_COEFF_READBACK_EN
                VERIFY: begin
                    if (mismatch_s) begin
                        err_r <= 1'b1;
                    end
                    if ((vidx_r + IDX_W'(1'b1)) < IDX_W'(NWORDS)) begin
                        rd_en   <= 1'b1;
                        rd_addr <= slot_addr(rk_r, rj_r);
                        if (rj_r == 2'd2) begin
                            rj_r <= 2'd0;
                            rk_r <= rk_r + 3'd1;
                        end else begin
                            rj_r <= rj_r + 2'd1;
                        end
                    end else begin
                        rd_en <= 1'b0;
                    end
                    if (vidx_r == IDX_W'(NWORDS)) begin
                        state_r <= FINISH;
                        busy    <= 1'b0;
                    end else begin
                        vidx_r <= vidx_r + IDX_W'(1'b1);
                    end
                end
`endif
                FINISH: begin
`ifdef IIR_COEFF_READBACK_EN
                    done <= ~err_r;
`else
                    done <= 1'b1;
`endif
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iir_coeff_loader.sv
// Randomized directed bench for iir_coeff_loader: instance 0 uses ORDER=3, instance 1 ORDER=7.
// A bank model answers reads; a monitor logs writes and status pulses for an index-based reference.
`timescale 1ns/1ps
module tb_iir_coeff_loader;
    localparam int NU   = 2;
    localparam int MAXW = 128;
`ifdef IIR_COEFF_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        corrupt;
    logic        start_s    [NU];
    logic [15:0] in_data_s  [NU];
    logic        in_valid_s [NU];
    logic        in_ready_s [NU];
    logic [15:0] wr_addr_s  [NU];
    logic [15:0] wr_data_s  [NU];
    logic        wr_en_s    [NU];
    logic        rd_en_s    [NU];
    logic [15:0] rd_addr_s  [NU];
    logic [15:0] rd_data_s  [NU] = '{16'h0000, 16'h0000};
    logic        busy_s     [NU];
    logic        done_s     [NU];
    logic        error_s    [NU];

    iir_coeff_loader #(.ORDER(3), .Y_BASE(15), .ADDR_W(16)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_s[0]), .in_data(in_data_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .wr_addr(wr_addr_s[0]),
        .wr_data(wr_data_s[0]), .wr_en(wr_en_s[0]), .rd_en(rd_en_s[0]), .rd_addr(rd_addr_s[0]),
        .rd_data(rd_data_s[0]), .busy(busy_s[0]), .done(done_s[0]), .error(error_s[0])
    );

    iir_coeff_loader #(.ORDER(7), .Y_BASE(15), .ADDR_W(16)) u_dut7 (
        .clk(clk), .reset(reset), .start(start_s[1]), .in_data(in_data_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .wr_addr(wr_addr_s[1]),
        .wr_data(wr_data_s[1]), .wr_en(wr_en_s[1]), .rd_en(rd_en_s[1]), .rd_addr(rd_addr_s[1]),
        .rd_data(rd_data_s[1]), .busy(busy_s[1]), .done(done_s[1]), .error(error_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc = 0;
    logic [15:0] bank [NU][32];
    logic [15:0] w_addr [NU][MAXW];
    logic [15:0] w_data [NU][MAXW];
    int          w_cyc  [NU][MAXW];
    int          w_cnt     [NU] = '{0, 0};
    int          done_cnt  [NU] = '{0, 0};
    int          done_cyc  [NU] = '{0, 0};
    int          busy_fall [NU] = '{0, 0};
    int          spurious  [NU] = '{0, 0};
    int          missing   [NU] = '{0, 0};
    logic        busy_prev [NU] = '{1'b0, 1'b0};
    logic        acc_next  [NU] = '{1'b0, 1'b0};

    // Bank model: writes land on the strobe edge, reads return one cycle later (addr 16 optionally corrupted).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < NU; g++) begin
            if (wr_en_s[g]) bank[g][wr_addr_s[g][4:0]] <= wr_data_s[g];
            if (rd_en_s[g]) rd_data_s[g] <= (corrupt && g == 0 && rd_addr_s[g] == 16'd16) ?
                                            16'h0000 : bank[g][rd_addr_s[g][4:0]];
        end
    end

    // Monitor: logs every write strobe and flags strobes that do not follow an accepted word.
    always @(negedge clk) begin
        for (int g = 0; g < NU; g++) begin
            if (!reset) begin
                acc_next[g]  <= 1'b0;
                busy_prev[g] <= 1'b0;
            end else begin
                if (wr_en_s[g]) begin
                    if (!acc_next[g]) spurious[g] <= spurious[g] + 1;
                    if (w_cnt[g] < MAXW) begin
                        w_addr[g][w_cnt[g]] <= wr_addr_s[g];
                        w_data[g][w_cnt[g]] <= wr_data_s[g];
                        w_cyc[g][w_cnt[g]]  <= cyc;
                    end
                    w_cnt[g] <= w_cnt[g] + 1;
                end else if (acc_next[g]) begin
                    missing[g] <= missing[g] + 1;
                end
                if (done_s[g]) begin
                    done_cnt[g] <= done_cnt[g] + 1;
                    done_cyc[g] <= cyc;
                end
                if (busy_prev[g] && !busy_s[g]) busy_fall[g] <= cyc;
                busy_prev[g] <= busy_s[g];
                acc_next[g]  <= in_valid_s[g] && in_ready_s[g];
            end
        end
    end

    int          tests = 0;
    int          fails = 0;
    int          gap_busy_low = 0;
    int          ready_to = 0;
    logic [15:0] words [NU][32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ord_of(input int u);
        return (u == 0) ? 3 : 7;
    endfunction

    // Word i belongs to section i/3, slot i%3: a0 -> 2k, a1 -> 2k+1, b1 -> 15+k.
    function automatic logic [15:0] ref_addr(input int i);
        int k;
        int j;
        k = i / 3;
        j = i % 3;
        if (j == 0) return 16'(2 * k);
        else if (j == 1) return 16'(2 * k + 1);
        else return 16'(15 + k);
    endfunction

    task automatic do_start(input int u);
        start_s[u] = 1'b1;
        tick();
        start_s[u] = 1'b0;
    endtask

    task automatic send(input int u, input logic [15:0] d, input int gap);
        int budget;
        budget = 20;
        in_valid_s[u] = 1'b1;
        in_data_s[u]  = d;
        while (!in_ready_s[u] && budget > 0) begin
            tick();
            budget--;
        end
        if (!in_ready_s[u]) ready_to++;
        tick();
        in_valid_s[u] = 1'b0;
        in_data_s[u]  = 16'($urandom);
        for (int g = 0; g < gap; g++) begin
            if (!busy_s[u]) gap_busy_low++;
            tick();
        end
    endtask

    task automatic run_load(input int u, input int n, input int gap, input int restart_after);
        for (int i = 0; i < n; i++) begin
            send(u, words[u][i], (i < n - 1) ? gap : 0);
            if (i == restart_after) do_start(u);
        end
    endtask

    task automatic wait_done(input int u, input int d0);
        int budget;
        budget = 200;
        while (done_cnt[u] == d0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (4) tick();
    endtask

    task automatic fill_random(input int u);
        for (int i = 0; i < 32; i++) words[u][i] = 16'($urandom);
    endtask

    task automatic check_run(input int u, input int base, input int d0, input int n,
                             input bit consec, input string tag);
        int last;
        int vc;
        vc = RB ? (3 * ord_of(u) + 1) : 0;
        chk({tag, "_nwr"}, w_cnt[u] - base, n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 32'(w_addr[u][base + i]), 32'(ref_addr(i)));
            chk({tag, "_data"}, 32'(w_data[u][base + i]), 32'(words[u][i]));
            if (consec && i > 0) chk({tag, "_cyc"}, w_cyc[u][base + i] - w_cyc[u][base], i);
        end
        last = w_cyc[u][base + n - 1];
        chk({tag, "_done_cnt"}, done_cnt[u] - d0, 1);
        chk({tag, "_done_cyc"}, done_cyc[u], last + 2 + vc);
        chk({tag, "_busy_fall"}, busy_fall[u], last + 1 + vc);
        chk({tag, "_error"}, 32'(error_s[u]), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        int bud;
        reset   = 1'b0;
        corrupt = 1'b0;
        for (int g = 0; g < NU; g++) begin
            start_s[g]    = 1'b0;
            in_valid_s[g] = 1'b0;
            in_data_s[g]  = 16'h0000;
        end
        repeat (3) tick();

        chk("rst_in_ready", 32'(in_ready_s[0]), 32'd0);
        chk("rst_wr_en",    32'(wr_en_s[0]),    32'd0);
        chk("rst_wr_addr",  32'(wr_addr_s[0]),  32'd0);
        chk("rst_wr_data",  32'(wr_data_s[0]),  32'd0);
        chk("rst_rd_en",    32'(rd_en_s[0]),    32'd0);
        chk("rst_rd_addr",  32'(rd_addr_s[0]),  32'd0);
        chk("rst_busy",     32'(busy_s[0]),     32'd0);
        chk("rst_done",     32'(done_s[0]),     32'd0);
        chk("rst_error",    32'(error_s[0]),    32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Back-to-back load with the ramp 0x0800 .. 0x4800.
        for (int i = 0; i < 9; i++) words[0][i] = 16'(16'h0800 * (i + 1));
        base = w_cnt[0];
        d0   = done_cnt[0];
        do_start(0);
        chk("t1_busy", 32'(busy_s[0]), 32'd1);
        chk("t1_in_ready", 32'(in_ready_s[0]), 32'd1);
        run_load(0, 9, 0, -1);
        wait_done(0, d0);
        check_run(0, base, d0, 9, 1'b1, "t1");

        // Three idle cycles between words.
        fill_random(0);
        base = w_cnt[0];
        d0   = done_cnt[0];
        do_start(0);
        run_load(0, 9, 3, -1);
        wait_done(0, d0);
        check_run(0, base, d0, 9, 1'b0, "t2");
        chk("t2_busy_gaps", gap_busy_low, 0);

        // A second start during LOAD is ignored.
        fill_random(0);
        base = w_cnt[0];
        d0   = done_cnt[0];
        do_start(0);
        run_load(0, 9, 0, 3);
        wait_done(0, d0);
        check_run(0, base, d0, 9, 1'b0, "t3");

        // Reset in the cycle after the fifth word is accepted, then reload.
        fill_random(0);
        do_start(0);
        for (int i = 0; i < 5; i++) send(0, words[0][i], 0);
        chk("t4_wr_en_pre", 32'(wr_en_s[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t4_wr_en_async",    32'(wr_en_s[0]),    32'd0);
        chk("t4_busy_async",     32'(busy_s[0]),     32'd0);
        chk("t4_in_ready_async", 32'(in_ready_s[0]), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        fill_random(0);
        base = w_cnt[0];
        d0   = done_cnt[0];
        do_start(0);
        run_load(0, 9, 0, -1);
        wait_done(0, d0);
        check_run(0, base, d0, 9, 1'b1, "t4");

`ifdef IIR_COEFF_READBACK_EN
        // Bank returns 0x0000 at address 16 where 0x4000 was written.
        fill_random(0);
        words[0][5] = 16'h4000;
        corrupt = 1'b1;
        base = w_cnt[0];
        d0   = done_cnt[0];
        do_start(0);
        run_load(0, 9, 0, -1);
        bud = 100;
        while (busy_s[0] && bud > 0) begin
            tick();
            bud--;
        end
        repeat (4) tick();
        chk("t5_error_set", 32'(error_s[0]), 32'd1);
        chk("t5_no_done", done_cnt[0] - d0, 0);
        chk("t5_busy_low", 32'(busy_s[0]), 32'd0);
        chk("t5_busy_fall", busy_fall[0], w_cyc[0][base + 8] + 1 + 10);
        corrupt = 1'b0;
        base = w_cnt[0];
        d0   = done_cnt[0];
        do_start(0);
        chk("t5_error_clr", 32'(error_s[0]), 32'd0);
        run_load(0, 9, 0, -1);
        wait_done(0, d0);
        check_run(0, base, d0, 9, 1'b1, "t5");
`endif

        // ORDER=7 full load on the second instance.
        fill_random(1);
        base = w_cnt[1];
        d0   = done_cnt[1];
        do_start(1);
        run_load(1, 21, 0, -1);
        wait_done(1, d0);
        check_run(1, base, d0, 21, 1'b1, "t6");
        chk("t6_last_b1", 32'(w_addr[1][base + 20]), 32'd21);
        chk("t6_a1_sec6", 32'(w_addr[1][base + 19]), 32'd13);

        chk("spurious_wr", spurious[0] + spurious[1], 0);
        chk("missing_wr", missing[0] + missing[1], 0);
        chk("ready_timeout", ready_to, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Bus initiator that programs the coefficient bank of the cascaded first-order IIR filter.
- Accepts a stream of 16-bit Q4.11 coefficient words over a valid/ready handshake.
- Maps each word to the bank address layout and issues single-cycle writes on the bank's address/data/write-strobe interface.
- Sits between the host/config path and the filter, so software never computes bank addresses.

Parameters:
- ORDER, 3, number of cascaded sections to program (1..7); the load length is 3*ORDER words.
- Y_BASE, 15, bank address of the first section's b1 coefficient.
- ADDR_W, 16, width of the bank address bus.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a load sequence
- in_data  input  16  coefficient word, Q4.11
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts in_data this cycle
- wr_addr  output  ADDR_W  bank write address
- wr_data  output  16  bank write data
- wr_en  output  1  bank write strobe, one cycle per word
- rd_en  output  1  bank read strobe (readback feature only)
- rd_addr  output  ADDR_W  bank read address (readback feature only)
- rd_data  input  16  bank read data, valid one cycle after rd_en
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when the sequence completes without error
- error  output  1  sticky readback mismatch flag; cleared by the next accepted start

Behaviour:
- Reset (reset=0, async): state=IDLE; section counter k=0; slot counter j=0. All outputs 0: in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, done, error.
- FSM states: IDLE, LOAD, DRAIN, VERIFY (readback only), FINISH.
- IDLE:
  - start=1 -> LOAD; k=0, j=0; busy=1; error cleared.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1 for the whole state; one word can be accepted per cycle.
  - A word is accepted on a rising edge with in_valid=1 and in_ready=1.
- Write mapping for the word at slot j of section k:
  - j=0 -> addr 2k (a0)
  - j=1 -> addr 2k+1 (a1)
  - j=2 -> addr Y_BASE+k (b1)
- Input word order is a0_0, a1_0, b1_0, a0_1, ... Counters only; no divider.
- Write timing:
  - wr_en, wr_addr and wr_data are registered.
  - A word accepted at edge N gives wr_en=1 with its addr/data for exactly the cycle after edge N.
  - wr_en=0 in all other cycles. wr_addr/wr_data hold their last value when idle.
- Counters: j wraps 2->0 and increments k.
- Completion of LOAD:
  - On acceptance of word 3*ORDER-1: in_ready drops at that edge and state -> DRAIN.
  - DRAIN lasts one cycle while the last write strobe is on the bus.
  - Then -> FINISH (or VERIFY when the readback feature is enabled).
- Backpressure: in_valid=0 cycles in LOAD produce no writes and no counter change. Gaps of any length are allowed; there is no timeout.
- FINISH: done=1 for exactly one cycle; busy=0 from the same edge; -> IDLE.
- busy is 1 from the edge after start through the last DRAIN/VERIFY cycle.
- Reset mid-sequence: everything returns to reset values immediately, including an in-flight wr_en. Partially written bank contents are not undone.
- Arithmetic: addresses are computed in ADDR_W bits with no overflow for ORDER<=7 (max address Y_BASE+6=21). Coefficient data passes through unmodified.

Optional Feature:
- Macro: IIR_COEFF_READBACK_EN.
- When defined:
  - Every accepted word is also stored in an internal 3*ORDER shadow buffer.
  - After DRAIN, the FSM enters VERIFY. It issues rd_en with rd_addr over the same address sequence, one address per cycle.
  - It compares rd_data, one cycle later, against the shadow buffer. Any mismatch sets error.
  - VERIFY lasts 3*ORDER+1 cycles.
  - On mismatch: FINISH is entered, done stays 0, error=1 and remains sticky.
- When undefined:
  - No shadow buffer and no VERIFY state; DRAIN goes directly to FINISH.
  - rd_en and rd_addr are tied 0, rd_data is ignored, and error is constant 0.

Test Plan:
- ORDER=3, start, then 9 back-to-back words 0x0800,0x1000,...,0x4800 -> wr_en for 9 consecutive cycles; addresses 0,1,15,2,3,16,4,5,17; data in input order; done pulses once, 2 cycles after the last write strobe (no readback).
- Same load with in_valid low for 3 cycles between every word -> identical address/data sequence; wr_en never high during a gap; busy held high throughout.
- start pulsed again after the 4th word -> ignored; sequence completes with 9 writes and a single done.
- reset asserted in the cycle after the 5th word is accepted -> wr_en, busy and in_ready drop asynchronously; a new start reloads from address 0.
- With IIR_COEFF_READBACK_EN, a bank model that corrupts address 16 (returns 0x0000 instead of 0x4000) -> error=1, done never pulses, busy drops after VERIFY; the next start clears error.
- ORDER=7 full load -> last b1 write lands at address 21; a1 of section 6 lands at address 13.
